// File: rtl/dpll_seq_pkg.sv
// dpll_seq_pkg: FSM states, register map, field positions and reset values shared by the
// PLL sequencer and its edge counter.
package dpll_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HOLD    = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_MEASURE = 3'd3,
      ST_COMPARE = 3'd4,
      ST_LOCKED  = 3'd5,
      ST_FAIL    = 3'd6
   } state_e;

   localparam logic [7:0] OFF_CTRL   = 8'h00;
   localparam logic [7:0] OFF_CFG    = 8'h04;
   localparam logic [7:0] OFF_MEAS   = 8'h08;
   localparam logic [7:0] OFF_STATUS = 8'h0C;

   localparam int CTRL_GO     = 0;
   localparam int CTRL_STOP   = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam int CFG_DIV_LSB    = 0;
   localparam int CFG_HOLD_LSB   = 8;
   localparam int CFG_SETTLE_LSB = 16;

   localparam int MEAS_EXP_LSB   = 0;
   localparam int MEAS_TOL_LSB   = 16;
   localparam int MEAS_RETRY_LSB = 24;

   localparam int STAT_LOCKED_BIT = 3;
   localparam int STAT_FAIL_BIT   = 4;
   localparam int STAT_LOST_BIT   = 5;
   localparam int STAT_RETRY_LSB  = 8;
   localparam int STAT_COUNT_LSB  = 16;

   localparam logic [31:0] CTRL_RST  = 32'h0000_0000;
   localparam logic [31:0] CFG_RST   = 32'h0100_1004;
   localparam logic [31:0] MEAS_RST  = 32'h0000_0000;
   localparam logic [31:0] CFG_MASK  = 32'hFFFF_FF1F;
   localparam logic [31:0] MEAS_MASK = 32'h0FFF_FFFF;

   function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dpll_edge_counter.sv
// dpll_edge_counter: brings the PLL feedback into the bus clock domain and counts its
// rising edges while the window is open, saturating at 0xFFFF.
module dpll_edge_counter
   import dpll_seq_pkg::*;
(
   input  logic        clk,
   input  logic        resetb,
   input  logic        fb_i,
   input  logic        clr_i,
   input  logic        en_i,
   output logic [15:0] count_o
);
   logic [2:0]  sync_q, sync_d;
   logic [15:0] count_q, count_d;
   logic        rise_s;

   // A rising edge is seen between the second and third synchronizer flops.
   always_comb begin
      sync_d = {sync_q[1:0], fb_i};
      rise_s = sync_q[1] & ~sync_q[2];
      if (clr_i) begin
         count_d = 16'd0;
      end else if (en_i && rise_s && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Synchronizer and counter state.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         sync_q  <= 3'd0;
         count_q <= 16'd0;
      end else begin
         sync_q  <= sync_d;
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/dpll_seq.sv
// dpll_seq: Wishbone-programmed power-up sequencer and lock monitor for the user-area PLL.
// Drives the PLL reset/enable/divider, counts feedback edges per window and tracks lock.
module dpll_seq
   import dpll_seq_pkg::*;
#(
   parameter logic [31:0] BASE_ADR = 32'h3000_0000,
   parameter int unsigned WIN_LOG2 = 10
) (
   input  logic        wb_clk_i,
   input  logic        resetb,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic        fb_i,
   output logic        pll_resetb_o,
   output logic        pll_enable_o,
   output logic [4:0]  pll_div_o,
   output logic        irq_o
);
   localparam logic [15:0] WIN_LAST = 16'((32'd1 << WIN_LOG2) - 32'd1);

   state_e      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic        irq_en_q, irq_en_d;
   logic [31:0] cfg_q, cfg_d, meas_q, meas_d;
   logic        locked_q, locked_d, fail_q, fail_d, lost_q, lost_d;
   logic [3:0]  retry_q, retry_d;
   logic [15:0] last_count_q, last_count_d;
   logic [4:0]  div_q, div_d;
   logic        ack_q, ack_d, enable_q, enable_d, pll_rstb_q, pll_rstb_d, irq_q, irq_d;
   logic [31:0] dat_q, dat_d, rdata_s;
   logic        req_s, wr_ctrl_s, wr_cfg_s, wr_meas_s, wr_stat_s;
   logic        go_s, stop_s, clr_fail_s, clr_lost_s;
   logic [15:0] count_s;
   logic        cnt_clr_s, cnt_en_s, hold_done_s, settle_done_s, win_done_s, hit_s;
   logic [16:0] diff_s;
   logic [4:0]  retry_inc_s;

   assign cnt_en_s  = (state_q == ST_MEASURE);
   assign cnt_clr_s = (state_q != ST_MEASURE) && (state_q != ST_COMPARE);

   dpll_edge_counter u_edge_counter (
      .clk     (wb_clk_i),
      .resetb  (resetb),
      .fb_i    (fb_i),
      .clr_i   (cnt_clr_s),
      .en_i    (cnt_en_s),
      .count_o (count_s)
   );

   // Wishbone decode, register writes and read mux; writes land on the acking edge.
   always_comb begin
      req_s      = wbs_stb_i & wbs_cyc_i & ~ack_q & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
      wr_ctrl_s  = req_s & wbs_we_i & (wbs_adr_i[7:0] == OFF_CTRL);
      wr_cfg_s   = req_s & wbs_we_i & (wbs_adr_i[7:0] == OFF_CFG);
      wr_meas_s  = req_s & wbs_we_i & (wbs_adr_i[7:0] == OFF_MEAS);
      wr_stat_s  = req_s & wbs_we_i & (wbs_adr_i[7:0] == OFF_STATUS);
      go_s       = wr_ctrl_s & wbs_sel_i[0] & wbs_dat_i[CTRL_GO];
      stop_s     = wr_ctrl_s & wbs_sel_i[0] & wbs_dat_i[CTRL_STOP];
      clr_fail_s = wr_stat_s & wbs_sel_i[0] & wbs_dat_i[STAT_FAIL_BIT];
      clr_lost_s = wr_stat_s & wbs_sel_i[0] & wbs_dat_i[STAT_LOST_BIT];
      irq_en_d   = (wr_ctrl_s & wbs_sel_i[0]) ? wbs_dat_i[CTRL_IRQ_EN] : irq_en_q;
      cfg_d      = wr_cfg_s  ? (apply_sel(cfg_q,  wbs_dat_i, wbs_sel_i) & CFG_MASK)  : cfg_q;
      meas_d     = wr_meas_s ? (apply_sel(meas_q, wbs_dat_i, wbs_sel_i) & MEAS_MASK) : meas_q;

      rdata_s = 32'd0;
      case (wbs_adr_i[7:0])
         OFF_CTRL:   rdata_s[CTRL_IRQ_EN] = irq_en_q;
         OFF_CFG:    rdata_s = cfg_q;
         OFF_MEAS:   rdata_s = meas_q;
         OFF_STATUS: begin
            rdata_s[2:0]                   = state_q;
            rdata_s[STAT_LOCKED_BIT]       = locked_q;
            rdata_s[STAT_FAIL_BIT]         = fail_q;
            rdata_s[STAT_LOST_BIT]         = lost_q;
            rdata_s[STAT_RETRY_LSB +: 4]   = retry_q;
            rdata_s[STAT_COUNT_LSB +: 16]  = last_count_q;
         end
         default:    rdata_s = 32'd0;
      endcase
      ack_d = req_s;
      dat_d = (req_s & ~wbs_we_i) ? rdata_s : 32'd0;
   end

   // Sequencer: next state, timers, lock bookkeeping and registered PLL outputs.
   always_comb begin
      hold_done_s   = ({1'b0, timer_q} + 17'd1) >= {9'd0, cfg_q[CFG_HOLD_LSB +: 8]};
      settle_done_s = ({1'b0, timer_q} + 17'd1) >= {1'b0, cfg_q[CFG_SETTLE_LSB +: 16]};
      win_done_s    = (timer_q == WIN_LAST);
      diff_s = ({1'b0, count_s} >= {1'b0, meas_q[MEAS_EXP_LSB +: 16]})
             ? ({1'b0, count_s} - {1'b0, meas_q[MEAS_EXP_LSB +: 16]})
             : ({1'b0, meas_q[MEAS_EXP_LSB +: 16]} - {1'b0, count_s});
      hit_s       = diff_s <= {9'd0, meas_q[MEAS_TOL_LSB +: 8]};
      retry_inc_s = {1'b0, retry_q} + 5'd1;

      state_d      = state_q;
      timer_d      = timer_q + 16'd1;
      div_d        = div_q;
      locked_d     = locked_q;
      fail_d       = fail_q & ~clr_fail_s;
      lost_d       = lost_q & ~clr_lost_s;
      retry_d      = retry_q;
      last_count_d = last_count_q;

      case (state_q)
         ST_IDLE, ST_FAIL: begin
            if (go_s) begin
               state_d = ST_HOLD;
               timer_d = 16'd0;
               div_d   = cfg_q[CFG_DIV_LSB +: 5];
               retry_d = 4'd0;
            end else begin
               timer_d = 16'd0;
            end
         end
         ST_HOLD: begin
            if (hold_done_s) begin
               state_d = ST_SETTLE;
               timer_d = 16'd0;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_SETTLE: begin
            if (settle_done_s) begin
               state_d = ST_MEASURE;
               timer_d = 16'd0;
            end else begin
               state_d = ST_SETTLE;
            end
         end
         ST_MEASURE: begin
            if (win_done_s) begin
               state_d = ST_COMPARE;
               timer_d = 16'd0;
            end else begin
               state_d = ST_MEASURE;
            end
         end
         ST_COMPARE: begin
            last_count_d = count_s;
            timer_d      = 16'd0;
            if (hit_s) begin
               state_d  = ST_LOCKED;
               locked_d = 1'b1;
            end else if (locked_q) begin
               state_d  = ST_HOLD;
               div_d    = cfg_q[CFG_DIV_LSB +: 5];
               lost_d   = 1'b1;
               locked_d = 1'b0;
               retry_d  = 4'd0;
            end else if (retry_inc_s >= {1'b0, meas_q[MEAS_RETRY_LSB +: 4]}) begin
               state_d = ST_FAIL;
               fail_d  = 1'b1;
               retry_d = retry_inc_s[3:0];
            end else begin
               state_d = ST_HOLD;
               div_d   = cfg_q[CFG_DIV_LSB +: 5];
               retry_d = retry_inc_s[3:0];
            end
         end
         ST_LOCKED: begin
            state_d = ST_MEASURE;
            timer_d = 16'd0;
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = 16'd0;
         end
      endcase

      if (stop_s) begin
         state_d  = ST_IDLE;
         timer_d  = 16'd0;
         locked_d = 1'b0;
      end else begin
         locked_d = locked_d;
      end

      enable_d   = (state_d != ST_IDLE) && (state_d != ST_FAIL);
      pll_rstb_d = enable_d && (state_d != ST_HOLD);
      irq_d      = irq_en_d & (fail_d | lost_d);
   end

   // All block state; synchronous active-low reset.
   always_ff @(posedge wb_clk_i) begin
      if (!resetb) begin
         state_q      <= ST_IDLE;
         timer_q      <= 16'd0;
         irq_en_q     <= CTRL_RST[CTRL_IRQ_EN];
         cfg_q        <= CFG_RST;
         meas_q       <= MEAS_RST;
         locked_q     <= 1'b0;
         fail_q       <= 1'b0;
         lost_q       <= 1'b0;
         retry_q      <= 4'd0;
         last_count_q <= 16'd0;
         div_q        <= 5'd0;
         ack_q        <= 1'b0;
         dat_q        <= 32'd0;
         enable_q     <= 1'b0;
         pll_rstb_q   <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         irq_en_q     <= irq_en_d;
         cfg_q        <= cfg_d;
         meas_q       <= meas_d;
         locked_q     <= locked_d;
         fail_q       <= fail_d;
         lost_q       <= lost_d;
         retry_q      <= retry_d;
         last_count_q <= last_count_d;
         div_q        <= div_d;
         ack_q        <= ack_d;
         dat_q        <= dat_d;
         enable_q     <= enable_d;
         pll_rstb_q   <= pll_rstb_d;
         irq_q        <= irq_d;
      end
   end

   assign wbs_ack_o    = ack_q;
   assign wbs_dat_o    = dat_q;
   assign pll_enable_o = enable_q;
   assign pll_resetb_o = pll_rstb_q;
   assign pll_div_o    = div_q;
   assign irq_o        = irq_q;

endmodule
